// File: rtl/uart_tx_scheduler.sv
// UART transmitter shared by NUM_REQ requesters through a round-robin arbiter.
// One character per frame: start, LSB-first data, optional parity, stop, optional idle gap.
module uart_tx_scheduler #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2,
  parameter int unsigned DIV_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DIV_W-1:0]     baud_div,
  input  logic [3:0]           cfg_data_bits,
  input  logic                 cfg_parity_en,
  input  logic [1:0]           cfg_parity_mode,
  input  logic [1:0]           cfg_stop_bits,
  input  logic [3:0]           cfg_interval,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ*9-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 uart_tx,
  output logic                 busy,
  output logic [ID_W-1:0]      grant_id
);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop, StGap} state_e;

  state_e           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d, cnt_q, cnt_d;
  logic [3:0]       bit_q, bit_d;
  logic [8:0]       data_q, data_d;
  logic [3:0]       data_last_q, data_last_d;
  logic [3:0]       stop_last_q, stop_last_d;
  logic [3:0]       interval_q, interval_d;
  logic             par_en_q, par_en_d;
  logic [1:0]       par_mode_q, par_mode_d;
  logic             tx_q, tx_d, busy_q, busy_d;
  logic [ID_W-1:0]  gid_q, gid_d, rr_q, rr_d;

  logic [8:0]       req_chr [NUM_REQ];
  logic [ID_W-1:0]  gnt_idx, idx;
  logic             gnt_found;
  logic [8:0]       par_mask;
  logic             par_xor, par_bit;
  logic [3:0]       bit_nxt;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_chr
    assign req_chr[g] = req_data[9*g +: 9];
  end

  // Parity covers only the transmitted bits; data_last is n-1 in 4..8.
  always_comb begin
    par_mask = 9'h1FF >> (4'd8 - data_last_q);
    par_xor  = ^(data_q & par_mask);
    unique case (par_mode_q)
      2'd0:    par_bit = par_xor;
      2'd1:    par_bit = ~par_xor;
      2'd2:    par_bit = 1'b0;
      default: par_bit = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      div_q       <= '0;
      cnt_q       <= '0;
      bit_q       <= '0;
      data_q      <= '0;
      data_last_q <= 4'd7;
      stop_last_q <= '0;
      interval_q  <= '0;
      par_en_q    <= 1'b0;
      par_mode_q  <= '0;
      tx_q        <= 1'b1;
      busy_q      <= 1'b0;
      gid_q       <= '0;
      rr_q        <= '0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      data_q      <= data_d;
      data_last_q <= data_last_d;
      stop_last_q <= stop_last_d;
      interval_q  <= interval_d;
      par_en_q    <= par_en_d;
      par_mode_q  <= par_mode_d;
      tx_q        <= tx_d;
      busy_q      <= busy_d;
      gid_q       <= gid_d;
      rr_q        <= rr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    data_d      = data_q;
    data_last_d = data_last_q;
    stop_last_d = stop_last_q;
    interval_d  = interval_q;
    par_en_d    = par_en_q;
    par_mode_d  = par_mode_q;
    tx_d        = tx_q;
    busy_d      = busy_q;
    gid_d       = gid_q;
    rr_d        = rr_q;
    bit_nxt     = bit_q + 4'd1;

    if (state_q == StIdle) begin
      if (gnt_found) begin
        state_d    = StStart;
        data_d     = req_chr[gnt_idx];
        par_en_d   = cfg_parity_en;
        par_mode_d = cfg_parity_mode;
        interval_d = cfg_interval;
        div_d      = baud_div;
        cnt_d      = baud_div;
        bit_d      = '0;
        tx_d       = 1'b0;
        busy_d     = 1'b1;
        gid_d      = gnt_idx;
        rr_d       = ID_W'((32'(gnt_idx) + 32'd1) % NUM_REQ);
        if (cfg_data_bits < 4'd5)      data_last_d = 4'd4;
        else if (cfg_data_bits > 4'd9) data_last_d = 4'd8;
        else                           data_last_d = cfg_data_bits - 4'd1;
        stop_last_d = (cfg_stop_bits >= 2'd2) ? 4'd1 : 4'd0;
      end
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - DIV_W'(1);
    end else begin
      cnt_d = div_q;
      bit_d = bit_nxt;
      unique case (state_q)
        StStart: begin
          state_d = StData;
          bit_d   = '0;
          tx_d    = data_q[0];
        end
        StData: begin
          if (bit_q == data_last_q) begin
            bit_d = '0;
            if (par_en_q) begin
              state_d = StParity;
              tx_d    = par_bit;
            end else begin
              state_d = StStop;
              tx_d    = 1'b1;
            end
          end else begin
            tx_d = data_q[bit_nxt];
          end
        end
        StParity: begin
          state_d = StStop;
          bit_d   = '0;
          tx_d    = 1'b1;
        end
        StStop: begin
          tx_d = 1'b1;
          if (bit_q == stop_last_q) begin
            bit_d = '0;
            if (interval_q != 4'd0) begin
              state_d = StGap;
            end else begin
              state_d = StIdle;
              busy_d  = 1'b0;
            end
          end
        end
        default: begin
          tx_d = 1'b1;
          if (bit_q == interval_q - 4'd1) begin
            state_d = StIdle;
            busy_d  = 1'b0;
            bit_d   = '0;
          end
        end
      endcase
    end
  end

  // Arbiter: first valid requester at or above rr pointer, wrapping modulo NUM_REQ.
  always_comb begin
    req_ready = '0;
    gnt_idx   = '0;
    gnt_found = 1'b0;
    idx       = '0;
    if (state_q == StIdle) begin
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
        idx = ID_W'((32'(rr_q) + k) % NUM_REQ);
        if (!gnt_found && req_valid[idx]) begin
          gnt_found = 1'b1;
          gnt_idx   = idx;
        end
      end
      if (gnt_found) req_ready[gnt_idx] = 1'b1;
    end
    uart_tx  = tx_q;
    busy     = busy_q;
    grant_id = gid_q;
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler: reset, framing, parity, arbitration, clamping,
// asynchronous reset mid-frame and mid-frame configuration changes.
module tb_uart_tx_scheduler;

  logic        clk, rst_n;
  logic [15:0] baud_div;
  logic [3:0]  cfg_data_bits;
  logic        cfg_parity_en;
  logic [1:0]  cfg_parity_mode;
  logic [1:0]  cfg_stop_bits;
  logic [3:0]  cfg_interval;
  logic [3:0]  req_valid;
  logic [35:0] req_data;
  logic [3:0]  req_ready;
  logic        uart_tx, busy;
  logic [1:0]  grant_id;

  int errors = 0;
  int checks = 0;

  uart_tx_scheduler #(.NUM_REQ(4), .ID_W(2), .DIV_W(16)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .baud_div        (baud_div),
    .cfg_data_bits   (cfg_data_bits),
    .cfg_parity_en   (cfg_parity_en),
    .cfg_parity_mode (cfg_parity_mode),
    .cfg_stop_bits   (cfg_stop_bits),
    .cfg_interval    (cfg_interval),
    .req_valid       (req_valid),
    .req_data        (req_data),
    .req_ready       (req_ready),
    .uart_tx         (uart_tx),
    .busy            (busy),
    .grant_id        (grant_id)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic set_cfg(input int div, input int nb, input bit pe, input int pm,
                         input int sb, input int iv);
    baud_div        = 16'(div);
    cfg_data_bits   = 4'(nb);
    cfg_parity_en   = pe;
    cfg_parity_mode = 2'(pm);
    cfg_stop_bits   = 2'(sb);
    cfg_interval    = 4'(iv);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Raise one request, wait for its grant, release it right after the accepting edge.
  task automatic send(input int r, input logic [8:0] d);
    bit ok = 1'b0;
    @(negedge clk);
    req_data[9*r +: 9] = d;
    req_valid[r] = 1'b1;
    for (int i = 0; i < 500; i++) begin
      #1;
      if (req_ready[r]) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (ok) begin
      @(posedge clk);
      #1;
    end else begin
      checks++;
      errors++;
      $display("FAIL send_grant: got no grant expected grant for req %0d", r);
    end
    req_valid[r] = 1'b0;
  endtask

  // Sample one bit per bit time starting from the first negedge with uart_tx low.
  task automatic capture_frame(input int div, input int nbits, output logic [15:0] bits,
                               output logic [1:0] gid, output bit ok);
    bits = '0;
    gid  = '0;
    ok   = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (uart_tx === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) begin
      gid     = grant_id;
      bits[0] = uart_tx;
      for (int k = 1; k < nbits; k++) begin
        repeat (div + 1) @(negedge clk);
        bits[k] = uart_tx;
      end
    end
  endtask

  task automatic wait_idle();
    bit done = 1'b0;
    checks++;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (busy === 1'b0) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) begin
      errors++;
      $display("FAIL wait_idle: got busy=%b expected busy=0 within 1000 clocks", busy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (uart_tx !== 1'b1) begin
      errors++; $display("FAIL reset_tx: got %b expected 1", uart_tx);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL reset_busy: got %b expected 0", busy);
    end
    checks++;
    if (req_ready !== 4'b0000) begin
      errors++; $display("FAIL reset_ready: got %b expected 0000", req_ready);
    end
    checks++;
    if (grant_id !== 2'd0) begin
      errors++; $display("FAIL reset_grant_id: got %0d expected 0", grant_id);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (uart_tx !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL reset_idle: got tx=%b busy=%b expected tx=1 busy=0", uart_tx, busy);
    end
  endtask

  task automatic test_single_frame();
    logic [43:0] v, exp_v;
    int bcnt = 0, rcnt = 0;
    set_cfg(3, 8, 1'b0, 0, 1, 0);
    @(negedge clk);
    req_data[8:0] = 9'h055;
    req_valid[0]  = 1'b1;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++; $display("FAIL t1_ready: got %b expected 0001", req_ready);
    end
    @(posedge clk);
    #1 req_valid[0] = 1'b0;
    for (int c = 0; c < 44; c++) begin
      @(negedge clk);
      v[c]     = uart_tx;
      exp_v[c] = (c < 40) ? ((c / 4) % 2 == 1) : 1'b1;
      if (busy === 1'b1) bcnt++;
      if (req_ready !== 4'b0000) rcnt++;
    end
    checks++;
    if (v !== exp_v) begin
      errors++; $display("FAIL t1_tx_pattern: got %h expected %h", v, exp_v);
    end
    checks++;
    if (bcnt != 40) begin
      errors++; $display("FAIL t1_busy_len: got %0d expected 40", bcnt);
    end
    checks++;
    if (rcnt != 0) begin
      errors++; $display("FAIL t1_ready_pulse: got %0d extra ready cycles expected 0", rcnt);
    end
  endtask

  task automatic test_parity_modes();
    logic [15:0] exp_tbl [4] = '{16'h0682, 16'h0782, 16'h0682, 16'h0782};
    logic [15:0] bits;
    logic [1:0]  gid;
    bit          ok;
    for (int m = 0; m < 4; m++) begin
      set_cfg(1, 7, 1'b1, m, 2, 0);
      send(0, 9'h1C1);
      capture_frame(1, 11, bits, gid, ok);
      checks++;
      if (!ok || bits !== exp_tbl[m]) begin
        errors++;
        $display("FAIL t2_parity_mode%0d: got %h expected %h", m, bits, exp_tbl[m]);
      end
      wait_idle();
    end
  endtask

  task automatic test_round_robin();
    logic [15:0] bits, exp_bits;
    logic [1:0]  gid;
    bit          ok;
    int          idle;
    do_reset();
    set_cfg(1, 8, 1'b0, 0, 1, 0);
    @(negedge clk);
    req_data  = {9'h0A3, 9'h0A2, 9'h0A1, 9'h0A0};
    req_valid = 4'hF;
    for (int f = 0; f < 5; f++) begin
      capture_frame(1, 10, bits, gid, ok);
      exp_bits = 16'h0200 | (16'(8'hA0 + 8'(f % 4)) << 1);
      checks++;
      if (!ok || gid !== 2'(f % 4)) begin
        errors++; $display("FAIL t3_grant%0d: got %0d expected %0d", f, gid, f % 4);
      end
      checks++;
      if (!ok || bits !== exp_bits) begin
        errors++; $display("FAIL t3_data%0d: got %h expected %h", f, bits, exp_bits);
      end
      if (f < 4) begin
        idle = 0;
        for (int j = 0; j < 10; j++) begin
          @(negedge clk);
          if (busy === 1'b0) idle++;
          else if (idle > 0) break;
        end
        checks++;
        if (idle != 1) begin
          errors++; $display("FAIL t3_gap%0d: got %0d idle clocks expected 1", f, idle);
        end
      end
    end
    req_valid = 4'h0;
    wait_idle();
  endtask

  task automatic test_clamp_interval();
    logic [31:0] v, exp_v;
    logic [15:0] bits;
    logic [1:0]  gid;
    bit          ok;
    int          bcnt = 0;
    set_cfg(1, 12, 1'b0, 0, 0, 3);
    send(2, 9'h1FF);
    for (int c = 0; c < 32; c++) begin
      @(negedge clk);
      v[c]     = uart_tx;
      exp_v[c] = (c >= 2);
      if (busy === 1'b1) bcnt++;
    end
    checks++;
    if (v !== exp_v) begin
      errors++; $display("FAIL t4_tx_pattern: got %h expected %h", v, exp_v);
    end
    checks++;
    if (bcnt != 28) begin
      errors++; $display("FAIL t4_busy_len: got %0d expected 28", bcnt);
    end
    wait_idle();
    send(2, 9'h0FF);
    capture_frame(1, 14, bits, gid, ok);
    checks++;
    if (!ok || bits !== 16'h3DFE) begin
      errors++; $display("FAIL t4_ninth_bit: got %h expected 3dfe", bits);
    end
    wait_idle();
  endtask

  task automatic test_reset_mid_frame();
    logic [15:0] bits;
    logic [1:0]  gid;
    bit          ok = 1'b0;
    set_cfg(3, 8, 1'b0, 0, 1, 0);
    @(negedge clk);
    req_data[17:9] = 9'h0F0;
    req_valid[1]   = 1'b1;
    for (int i = 0; i < 100; i++) begin
      #1;
      if (req_ready[1]) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    @(posedge clk);
    repeat (18) @(negedge clk);
    checks++;
    if (!ok || uart_tx !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL t5_pre_reset: got tx=%b busy=%b expected tx=0 busy=1", uart_tx, busy);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (uart_tx !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL t5_async_reset: got tx=%b busy=%b expected tx=1 busy=0", uart_tx, busy);
    end
    checks++;
    if (grant_id !== 2'd0) begin
      errors++; $display("FAIL t5_reset_grant_id: got %0d expected 0", grant_id);
    end
    @(negedge clk);
    rst_n = 1'b1;
    capture_frame(3, 10, bits, gid, ok);
    checks++;
    if (!ok || gid !== 2'd1 || bits !== 16'h03E0) begin
      errors++; $display("FAIL t5_regrant: got id=%0d bits=%h expected id=1 bits=03e0", gid, bits);
    end
    req_valid[1] = 1'b0;
    wait_idle();
  endtask

  task automatic test_cfg_change();
    logic [25:0] v;
    logic [15:0] bits_a, bits;
    logic [1:0]  gid;
    bit          ok;
    int          bcnt = 0;
    set_cfg(1, 8, 1'b0, 0, 1, 0);
    send(0, 9'h03C);
    for (int c = 0; c < 26; c++) begin
      @(negedge clk);
      v[c] = uart_tx;
      if (busy === 1'b1) bcnt++;
      if (c == 6) set_cfg(1, 7, 1'b1, 0, 2, 0);
    end
    bits_a = '0;
    for (int k = 0; k < 10; k++) bits_a[k] = v[2*k];
    checks++;
    if (bits_a !== 16'h0278) begin
      errors++; $display("FAIL t6_frame_a_bits: got %h expected 0278", bits_a);
    end
    checks++;
    if (bcnt != 20) begin
      errors++; $display("FAIL t6_frame_a_len: got %0d expected 20", bcnt);
    end
    send(3, 9'h0D5);
    capture_frame(1, 11, bits, gid, ok);
    checks++;
    if (!ok || gid !== 2'd3 || bits !== 16'h06AA) begin
      errors++; $display("FAIL t6_frame_b: got id=%0d bits=%h expected id=3 bits=06aa", gid, bits);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL t6_frame_b_stop2: got busy=%b expected 1", busy);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL t6_frame_b_end: got busy=%b expected 0", busy);
    end
  endtask

  initial begin
    rst_n     = 1'b1;
    req_valid = 4'h0;
    req_data  = '0;
    set_cfg(3, 8, 1'b0, 0, 1, 0);
    test_reset();
    test_single_frame();
    test_parity_modes();
    test_round_robin();
    test_clamp_interval();
    test_reset_mid_frame();
    test_cfg_change();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
